// File: rtl/dq_pkg.sv
// dq_pkg: shared helpers and reset constants for the dq_regfile register bank.
package dq_pkg;

    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam bit RST_BIT = 1'b0;

endpackage

// File: rtl/dq_word.sv
// dq_word: one enabled storage word with its initialised flag; clear wins over write.
module dq_word
    import dq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             init
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= {WIDTH{RST_BIT}};
            init <= 1'b0;
        end else if (clr) begin
            q    <= {WIDTH{RST_BIT}};
            init <= 1'b0;
        end else if (we) begin
            q    <= d;
            init <= 1'b1;
        end
    end

endmodule

// File: rtl/dq_regfile.sv
// dq_regfile: DEPTH x WIDTH register bank with registered read port, write bypass,
// initialised-word count and out-of-range error pulse.
module dq_regfile
    import dq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = addrWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic             clr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rinit,
    output logic [AW:0]      cnt,
    output logic             err
);

    localparam bit POW2 = (DEPTH == (1 << AW));

    logic [DEPTH-1:0][WIDTH-1:0] memQ;
    logic [DEPTH-1:0]            initQ;
    logic [DEPTH-1:0]            wen;
    logic [WIDTH-1:0]            rdMem;
    logic                        rdInit;
    logic                        wIn;
    logic                        rIn;
    logic                        bypass;
    logic                        newWord;

    assign wIn     = POW2 || (int'(waddr) < DEPTH);
    assign rIn     = POW2 || (int'(raddr) < DEPTH);
    assign bypass  = rIn && we && !clr && (waddr == raddr);
    assign newWord = |(wen & ~initQ);

    // Out-of-range addresses match no word, so they neither write nor read.
    always_comb begin
        wen    = '0;
        rdMem  = '0;
        rdInit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wen[i] = we && !clr && (int'(waddr) == i);
            rdMem  = (int'(raddr) == i) ? memQ[i] : rdMem;
            rdInit = (int'(raddr) == i) ? initQ[i] : rdInit;
        end
    end

    dq_word #(.WIDTH(WIDTH)) uWord [DEPTH-1:0] (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .we   (wen),
        .d    (wdata),
        .q    (memQ),
        .init (initQ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= {WIDTH{RST_BIT}};
            rvalid <= 1'b0;
            rinit  <= 1'b0;
            cnt    <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= re;
            err    <= (we && !wIn) || (re && !rIn);
            cnt    <= clr ? '0 : cnt + (AW+1)'(newWord);
            if (re) begin
                rdata <= bypass ? wdata : rdMem;
                rinit <= bypass || rdInit;
            end
        end
    end

endmodule
